if_bpu: RTL

- Fetch-side program counter generator and conditional-branch predictor.
- Drives the fetch PC and the per-instruction `take` prediction into the IF/ID register.
- Consumes the misprediction redirect (`predict_fail`, `fail_addr`) and branch outcomes from the execute stage.
- Trains a PC-indexed table of 2-bit saturating counters and keeps branch/miss statistics.

---
 rtl/if_bpu.sv | 119 +++++++++++
 1 files changed

// File: rtl/if_bpu.sv
// Fetch PC generator with a PC-indexed 2-bit saturating-counter branch predictor.
// Optional macro JAL_PREDICT_EN: predict JAL as always taken toward its J-immediate target.
module if_bpu #(
  parameter int                 PC_SIZE   = 32,
  parameter int                 BHT_IDX_W = 6,
  parameter logic [PC_SIZE-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [31:0]        if_inst,
  output logic [PC_SIZE-1:0] pc,
  output logic               take,
  input  logic               predict_fail,
  input  logic [PC_SIZE-1:0] fail_addr,
  input  logic               ex_branch,
  input  logic [PC_SIZE-1:0] ex_pc,
  input  logic               ex_taken,
  output logic [31:0]        branch_cnt,
  output logic [31:0]        miss_cnt
);

  localparam int BHT_N = 2 ** BHT_IDX_W;

  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [1:0]         bht_q [BHT_N];
  logic [1:0]         bht_d [BHT_N];
  logic [31:0]        branch_cnt_q, branch_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;

  logic                 is_bxx;
  logic [PC_SIZE-1:0]   bxx_off;
  logic [PC_SIZE-1:0]   tgt_off;
  logic [BHT_IDX_W-1:0] idx;
  logic [BHT_IDX_W-1:0] uidx;
  logic [1:0]           ctr;
  logic                 take_pred;
`ifdef JAL_PREDICT_EN
  logic                 is_jal;
  logic [PC_SIZE-1:0]   jal_off;
`endif

  logic unused_bits;
  assign unused_bits = ^{if_inst[24:12], ex_pc[PC_SIZE-1:BHT_IDX_W+2], ex_pc[1:0]};

  // Predict from the stored counter only; a same-cycle update is seen next cycle.
  always_comb begin
    is_bxx    = (if_inst[6:0] == 7'b1100011);
    bxx_off   = {{(PC_SIZE-13){if_inst[31]}}, if_inst[31], if_inst[7],
                 if_inst[30:25], if_inst[11:8], 1'b0};
    idx       = pc_q[BHT_IDX_W+1:2];
    ctr       = bht_q[idx];
    take_pred = is_bxx & ctr[1];
    tgt_off   = bxx_off;
`ifdef JAL_PREDICT_EN
    is_jal    = (if_inst[6:0] == 7'b1101111);
    jal_off   = {{(PC_SIZE-21){if_inst[31]}}, if_inst[31], if_inst[19:12],
                 if_inst[20], if_inst[30:21], 1'b0};
    if (is_jal) begin
      take_pred = 1'b1;
      tgt_off   = jal_off;
    end
`endif
    take = take_pred & ~rst;
  end

  always_comb begin
    pc_d = pc_q + PC_SIZE'(4);
    if (predict_fail) begin
      pc_d = fail_addr;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (take) begin
      pc_d = pc_q + tgt_off;
    end
  end

  // Training and statistics run regardless of stall or redirect.
  always_comb begin
    bht_d        = bht_q;
    uidx         = ex_pc[BHT_IDX_W+1:2];
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (ex_branch) begin
      if (ex_taken && bht_q[uidx] != 2'b11) begin
        bht_d[uidx] = bht_q[uidx] + 2'b01;
      end else if (!ex_taken && bht_q[uidx] != 2'b00) begin
        bht_d[uidx] = bht_q[uidx] - 2'b01;
      end
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (predict_fail) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      pc_q         <= pc_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign pc         = pc_q;
  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule
